// File: rtl/vram_write_queue.sv
// CPU-to-VRAM write FIFO: buffers CPU writes and drains one per cycle while the video timing allows writes.
// Optional VRAM_WRITE_QUEUE_DROP_COUNT_EN adds a saturating dropped-write counter output.
module vram_write_queue #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_WIDTH-1:0]    cpu_address,
  input  logic [7:0]               cpu_data,
  input  logic                     cpu_write_enable,
  input  logic                     writable,
  input  logic                     clr_overflow,
  output logic [ADDR_WIDTH-1:0]    vram_address,
  output logic [7:0]               vram_data,
  output logic                     vram_write_enable,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
`ifdef VRAM_WRITE_QUEUE_DROP_COUNT_EN
  ,
  output logic [7:0]               drop_count
`endif
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic {IDLE, DRAIN} state_t;
  state_t state, state_nxt;

  logic [ADDR_WIDTH+7:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic                  push, pop, drop;

  assign full  = (level == (PW+1)'(DEPTH));
  assign empty = (level == '0);

  // A pop frees a slot in the same edge, so a write into a full FIFO is still accepted then.
  assign push = cpu_write_enable && (!full || pop);
  assign drop = cpu_write_enable && full && !pop;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (writable && !empty) begin
          pop       = 1'b1;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!writable) begin
          state_nxt = IDLE;
        end else if (!empty) begin
          pop = 1'b1;
          if (level == (PW+1)'(1) && !cpu_write_enable) state_nxt = IDLE;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Storage has no reset; only pointers and level define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cpu_address, cpu_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      level             <= '0;
      overflow          <= 1'b0;
      vram_write_enable <= 1'b0;
      vram_address      <= '0;
      vram_data         <= '0;
    end else begin
      state             <= state_nxt;
      vram_write_enable <= pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr                    <= rd_ptr + 1'b1;
        {vram_address, vram_data} <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (clr_overflow) overflow <= 1'b0;
      else if (drop)    overflow <= 1'b1;
    end
  end

`ifdef VRAM_WRITE_QUEUE_DROP_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             drop_count <= '0;
    else if (clr_overflow)                drop_count <= '0;
    else if (drop && drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_vram_write_queue.sv
// Bench for vram_write_queue: vector table, directed corner sequences and random traffic
// checked every cycle against a queue-based reference model.
module tb_vram_write_queue;
  localparam int DEPTH = 16;
  localparam int AW    = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] cpu_address;
  logic [7:0]    cpu_data;
  logic          cpu_write_enable, writable, clr_overflow;
  logic [AW-1:0] vram_address;
  logic [7:0]    vram_data;
  logic          vram_write_enable, full, empty, overflow;
  logic [4:0]    level;
`ifdef VRAM_WRITE_QUEUE_DROP_COUNT_EN
  logic [7:0]    drop_count;
`endif

  vram_write_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .cpu_address(cpu_address), .cpu_data(cpu_data), .cpu_write_enable(cpu_write_enable),
    .writable(writable), .clr_overflow(clr_overflow),
    .vram_address(vram_address), .vram_data(vram_data), .vram_write_enable(vram_write_enable),
    .full(full), .empty(empty), .level(level), .overflow(overflow)
`ifdef VRAM_WRITE_QUEUE_DROP_COUNT_EN
    , .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int strobes = 0;

  // Reference model: a plain queue of pending writes plus the last emitted write.
  typedef struct { logic [AW-1:0] a; logic [7:0] d; } ent_t;
  ent_t          q[$];
  logic          m_vwe;
  logic [AW-1:0] m_a;
  logic [7:0]    m_d;
  logic          m_ovf;
  int            m_dc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    m_vwe = 1'b0; m_a = '0; m_d = '0; m_ovf = 1'b0; m_dc = 0;
  endtask

  task automatic model_step(input logic we, input logic [AW-1:0] a, input logic [7:0] d,
                            input logic wr, input logic clr);
    bit pop, was_full, push, drop;
    ent_t e;
    pop      = wr && q.size() > 0;
    was_full = q.size() == DEPTH;
    push     = we && (!was_full || pop);
    drop     = we && was_full && !pop;
    m_vwe    = pop;
    if (pop) begin
      e = q.pop_front();
      m_a = e.a; m_d = e.d;
    end
    if (push) begin
      e.a = a; e.d = d;
      q.push_back(e);
    end
    if (clr) begin m_ovf = 1'b0; m_dc = 0; end
    else if (drop) begin m_ovf = 1'b1; if (m_dc < 255) m_dc++; end
  endtask

  task automatic compare_model();
    chk("vram_write_enable", vram_write_enable, m_vwe);
    chk("vram_address", vram_address, m_a);
    chk("vram_data", vram_data, m_d);
    chk("level", level, q.size());
    chk("empty", empty, q.size() == 0);
    chk("full", full, q.size() == DEPTH);
    chk("overflow", overflow, m_ovf);
`ifdef VRAM_WRITE_QUEUE_DROP_COUNT_EN
    chk("drop_count", drop_count, m_dc);
`endif
  endtask

  // One clock: drive inputs away from the edge, advance model at the edge, sample 1ns later.
  task automatic cyc(input logic we, input logic [AW-1:0] a, input logic [7:0] d,
                     input logic wr, input logic clr);
    cpu_write_enable = we; cpu_address = a; cpu_data = d; writable = wr; clr_overflow = clr;
    @(posedge clk);
    model_step(we, a, d, wr, clr);
    #1;
    if (vram_write_enable === 1'b1) strobes++;
    compare_model();
  endtask

  task automatic drain_all();
    for (int i = 0; i < DEPTH + 2; i++) cyc(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  typedef struct {
    logic we; logic [AW-1:0] a; logic [7:0] d; logic wr; logic clr;
    logic e_vwe; logic [AW-1:0] e_a; logic [7:0] e_d; int e_lvl;
  } vec_t;
  vec_t vt[8];

  initial begin
    vt[0] = '{1'b1, 12'h010, 8'hAA, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1};
    vt[1] = '{1'b1, 12'h011, 8'hBB, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 2};
    vt[2] = '{1'b1, 12'h012, 8'hCC, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 3};
    vt[3] = '{1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 3};
    vt[4] = '{1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b1, 12'h010, 8'hAA, 2};
    vt[5] = '{1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b1, 12'h011, 8'hBB, 1};
    vt[6] = '{1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b1, 12'h012, 8'hCC, 0};
    vt[7] = '{1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b0, 12'h012, 8'hCC, 0};

    rst = 1'b0; cpu_write_enable = 1'b0; cpu_address = '0; cpu_data = '0;
    writable = 1'b0; clr_overflow = 1'b0;
    model_reset();
    #1;
    chk("rst_vwe", vram_write_enable, 1'b0);
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_addr", vram_address, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Buffered writes while blocked, then a burst drain.
    for (int i = 0; i < 8; i++) begin
      cyc(vt[i].we, vt[i].a, vt[i].d, vt[i].wr, vt[i].clr);
      chk("vec_vwe", vram_write_enable, vt[i].e_vwe);
      chk("vec_addr", vram_address, vt[i].e_a);
      chk("vec_data", vram_data, vt[i].e_d);
      chk("vec_level", level, vt[i].e_lvl);
    end
    chk("vec_empty", empty, 1'b1);

    // Minimum latency: write in cycle N, strobe in cycle N+2.
    cyc(1'b1, 12'h3C3, 8'h5A, 1'b1, 1'b0);
    chk("lat_n1_vwe", vram_write_enable, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
    chk("lat_n2_vwe", vram_write_enable, 1'b1);
    chk("lat_n2_addr", vram_address, 12'h3C3);
    cyc(1'b0, '0, '0, 1'b1, 1'b0);

    // Overflow: 17 writes into 16 entries; 17th must never come out.
    for (int i = 0; i < 17; i++) begin
      cyc(1'b1, 12'h100 + 12'(i), 8'(i), 1'b0, 1'b0);
      if (i == 15) begin
        chk("ovf_full", full, 1'b1);
        chk("ovf_not_yet", overflow, 1'b0);
      end
    end
    chk("ovf_set", overflow, 1'b1);
    chk("ovf_level", level, 16);
`ifdef VRAM_WRITE_QUEUE_DROP_COUNT_EN
    chk("ovf_dc1", drop_count, 1);
`endif
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, '0, '0, 1'b1, 1'b0);
      chk("ovf_drain_addr", vram_address, 12'h100 + 12'(i));
    end
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
    chk("ovf_17th_absent", vram_write_enable, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    chk("ovf_cleared", overflow, 1'b0);
`ifdef VRAM_WRITE_QUEUE_DROP_COUNT_EN
    chk("ovf_dc0", drop_count, 0);
`endif

    // Writable window of three cycles, then resume.
    for (int i = 0; i < 8; i++) cyc(1'b1, 12'h200 + 12'(i), 8'h80 + 8'(i), 1'b0, 1'b0);
    strobes = 0;
    repeat (3) cyc(1'b0, '0, '0, 1'b1, 1'b0);
    repeat (3) cyc(1'b0, '0, '0, 1'b0, 1'b0);
    chk("win_strobes3", strobes, 3);
    chk("win_level5", level, 5);
    strobes = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, '0, '0, 1'b1, 1'b0);
      if (i < 5) chk("win_resume_addr", vram_address, 12'h203 + 12'(i));
    end
    chk("win_strobes5", strobes, 5);

    // Push into a full FIFO on the same edge as a pop.
    for (int i = 0; i < 16; i++) cyc(1'b1, 12'h300 + 12'(i), 8'(i), 1'b0, 1'b0);
    cyc(1'b1, 12'h2AA, 8'h55, 1'b1, 1'b0);
    chk("fullpp_level", level, 16);
    chk("fullpp_ovf", overflow, 1'b0);
    chk("fullpp_vwe", vram_write_enable, 1'b1);
    for (int i = 0; i < 16; i++) cyc(1'b0, '0, '0, 1'b1, 1'b0);
    chk("fullpp_last", vram_address, 12'h2AA);
    drain_all();

    // Reset mid-drain with entries left.
    for (int i = 0; i < 8; i++) cyc(1'b1, 12'h400 + 12'(i), 8'(i), 1'b0, 1'b0);
    repeat (3) cyc(1'b0, '0, '0, 1'b1, 1'b0);
    rst = 1'b0;
    model_reset();
    #1;
    chk("mrst_vwe", vram_write_enable, 1'b0);
    chk("mrst_addr", vram_address, 0);
    chk("mrst_data", vram_data, 0);
    chk("mrst_level", level, 0);
    chk("mrst_empty", empty, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    strobes = 0;
    repeat (6) cyc(1'b0, '0, '0, 1'b1, 1'b0);
    chk("mrst_no_strobes", strobes, 0);

    // Random traffic against the model.
    writable = 1'b0;
    for (int i = 0; i < 600; i++) begin
      logic we, wr, clr;
      we  = $urandom_range(0, 9) < ((i / 100) % 2 == 0 ? 7 : 3);
      wr  = (i % 40) < 15 ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr = $urandom_range(0, 29) == 0;
      cyc(we, 12'($urandom), 8'($urandom), wr, clr);
    end
    drain_all();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
